// File: rtl/difftest_int_wb_queue.sv
// Integer writeback event queue: up to two events per cycle into a circular FIFO, drained one per cycle.
// Latency: one cycle from input to head, with no combinational input-to-output path.
// Backpressure: out_ready stalls the head; events beyond free space are dropped and counted.
// Optional DIFFTEST_WB_FILTER_X0_EN: discard address-0 events before enqueue.
module difftest_int_wb_queue #(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in0_valid,
   input  logic [4:0]        in0_address,
   input  logic [63:0]       in0_data,
   input  logic              in1_valid,
   input  logic [4:0]        in1_address,
   input  logic [63:0]       in1_data,
   input  logic [7:0]        coreid,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [4:0]        out_address,
   output logic [63:0]       out_data,
   output logic [7:0]        out_coreid,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int DW1 = DROP_W + 1;

   logic [4:0]        addr_mem [DEPTH];
   logic [63:0]       data_mem [DEPTH];

   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              v0, v1;
   logic              deq;
   logic [CW-1:0]     space;
   logic              acc0, acc1;
   logic [1:0]        n_drop;
   logic [PW-1:0]     wr1_ptr;
   logic [DW1-1:0]    drop_sum;

`ifdef DIFFTEST_WB_FILTER_X0_EN
   assign v0 = in0_valid && (in0_address != 5'd0);
   assign v1 = in1_valid && (in1_address != 5'd0);
`else
   assign v0 = in0_valid;
   assign v1 = in1_valid;
`endif

   // A slot vacated by this cycle's dequeue is reusable by this cycle's enqueue.
   always_comb begin
      deq      = (count_q != '0) && out_ready;
      space    = CW'(DEPTH) - count_q + CW'(deq);
      acc0     = v0 && (space != '0);
      acc1     = v1 && (acc0 ? (space >= CW'(2)) : (space != '0));
      n_drop   = {1'b0, v0 && !acc0} + {1'b0, v1 && !acc1};
      wr1_ptr  = wr_ptr_q + PW'(acc0);
      drop_sum = {1'b0, drop_cnt_q} + DW1'(n_drop);

      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d    = count_q + CW'(acc0) + CW'(acc1) - CW'(deq);
         rd_ptr_d   = rd_ptr_q + PW'(deq);
         wr_ptr_d   = wr_ptr_q + PW'(acc0) + PW'(acc1);
         overflow_d = overflow_q | (n_drop != 2'd0);
         drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Payload storage carries no reset; contents only matter behind count_q.
   always_ff @(posedge clock) begin
      if (!flush) begin
         if (acc0) begin
            addr_mem[wr_ptr_q] <= in0_address;
            data_mem[wr_ptr_q] <= in0_data;
         end
         if (acc1) begin
            addr_mem[wr1_ptr] <= in1_address;
            data_mem[wr1_ptr] <= in1_data;
         end
      end
   end

   assign out_valid   = (count_q != '0);
   assign out_address = addr_mem[rd_ptr_q];
   assign out_data    = data_mem[rd_ptr_q];
   assign out_coreid  = coreid;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_difftest_int_wb_queue.sv
// Scoreboard bench for difftest_int_wb_queue: reference queue updated as stimulus is applied,
// head/flags compared every cycle on the falling edge.
module tb_difftest_int_wb_queue;

   localparam int DEPTH  = 8;
   localparam int DROP_W = 16;

   logic              clock;
   logic              reset;
   logic              flush;
   logic              in0_valid;
   logic [4:0]        in0_address;
   logic [63:0]       in0_data;
   logic              in1_valid;
   logic [4:0]        in1_address;
   logic [63:0]       in1_data;
   logic [7:0]        coreid;
   logic              out_ready;
   logic              out_valid;
   logic [4:0]        out_address;
   logic [63:0]       out_data;
   logic [7:0]        out_coreid;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   difftest_int_wb_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in0_valid(in0_valid), .in0_address(in0_address), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_address(in1_address), .in1_data(in1_data),
      .coreid(coreid), .out_ready(out_ready),
      .out_valid(out_valid), .out_address(out_address), .out_data(out_data),
      .out_coreid(out_coreid), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  a;
      logic [63:0] d;
   } ent_t;

   ent_t sb[$];
   int   m_drop;
   bit   m_ovf;
   int   n_checks;
   int   n_errors;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit keep(input logic [4:0] a);
`ifdef DIFFTEST_WB_FILTER_X0_EN
      return a != 5'd0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_push(input logic [4:0] a, input logic [63:0] d);
      ent_t e;
      if (!keep(a)) return;
      if (sb.size() < DEPTH) begin
         e.a = a;
         e.d = d;
         sb.push_back(e);
      end else begin
         m_drop++;
         m_ovf = 1'b1;
      end
   endtask

   // Called just after a rising edge with inputs set; returns just after the next rising edge.
   task automatic step();
      ent_t h;
      @(negedge clock);
      check_eq("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
         h = sb[0];
         check_eq("out_address", out_address, h.a);
         check_eq("out_data", out_data, h.d);
      end
      check_eq("overflow", overflow, m_ovf);
      check_eq("drop_cnt", drop_cnt, m_drop);
      check_eq("out_coreid", out_coreid, coreid);
      if (flush) begin
         sb.delete();
      end else begin
         if (sb.size() != 0 && out_ready) void'(sb.pop_front());
         if (in0_valid) model_push(in0_address, in0_data);
         if (in1_valid) model_push(in1_address, in1_data);
         if (m_drop > 65535) m_drop = 65535;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic rdy, input logic fl);
      in0_valid   = v0;
      in0_address = a0;
      in0_data    = d0;
      in1_valid   = v1;
      in1_address = a1;
      in1_data    = d1;
      out_ready   = rdy;
      flush       = fl;
      step();
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, rdy, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_drop   = 0;
      m_ovf    = 1'b0;
      reset = 1'b0; flush = 1'b0; coreid = 8'h5A; out_ready = 1'b0;
      in0_valid = 1'b0; in0_address = '0; in0_data = '0;
      in1_valid = 1'b0; in1_address = '0; in1_data = '0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_overflow", overflow, 1'b0);
      check_eq("rst_drop_cnt", drop_cnt, 16'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Single event, one-cycle latency, then empty.
      drive(1, 5'd5, 64'hDEAD_BEEF, 0, 5'd0, 64'd0, 1, 0);
      check_eq("lat_valid", out_valid, 1'b1);
      check_eq("lat_addr", out_address, 5'd5);
      check_eq("lat_data", out_data, 64'hDEAD_BEEF);
      idle(1, 2);

      // Dual write, in0 ahead of in1; head held while stalled.
      drive(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 0);
      idle(0, 2);
      idle(1, 3);

      // Fill past DEPTH with dual writes: 8 held, 2 dropped.
      for (int i = 0; i < 5; i++)
         drive(1, 5'(2 * i + 3), 64'(100 + 2 * i), 1, 5'(2 * i + 4), 64'(101 + 2 * i), 0, 0);
      check_eq("fill_drop_cnt", drop_cnt, 16'd2);
      check_eq("fill_overflow", overflow, 1'b1);
      // Full with same-cycle dequeue: in0 is accepted.
      drive(1, 5'd30, 64'hF00D, 0, 5'd0, 64'd0, 1, 0);
      check_eq("full_deq_drop_cnt", drop_cnt, 16'd2);
      idle(1, 10);

      // Space of one with two arrivals: in0 kept, in1 dropped.
      for (int i = 0; i < 3; i++)
         drive(1, 5'(i + 10), 64'(200 + i), 1, 5'(i + 20), 64'(300 + i), 0, 0);
      drive(1, 5'd13, 64'd203, 0, 5'd0, 64'd0, 0, 0);
      drive(1, 5'd14, 64'd204, 1, 5'd24, 64'd304, 0, 0);
      check_eq("space1_drop_cnt", drop_cnt, 16'd3);
      idle(1, 10);

      // Random traffic, exercises wrap-around and mixed stalls.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
               $urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
               $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      idle(1, 10);

      // Flush with a concurrent enqueue.
      for (int i = 0; i < 3; i++) drive(1, 5'(i + 1), 64'(i + 7), 0, 5'd0, 64'd0, 0, 0);
      drive(1, 5'd9, 64'h99, 0, 5'd0, 64'd0, 0, 1);
      check_eq("flush_valid", out_valid, 1'b0);
      idle(1, 2);

      // Asynchronous reset mid-burst.
      drive(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0, 0);
      drive(1, 5'd5, 64'h55, 1, 5'd6, 64'h66, 0, 0);
      reset = 1'b0;
      #1;
      check_eq("midrst_valid", out_valid, 1'b0);
      check_eq("midrst_drop_cnt", drop_cnt, 16'd0);
      check_eq("midrst_overflow", overflow, 1'b0);
      sb.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      drive(1, 5'd7, 64'h77, 0, 5'd0, 64'd0, 1, 0);
      idle(1, 2);

      // Address-0 event.
      drive(1, 5'd0, 64'h5, 0, 5'd0, 64'd0, 1, 0);
`ifdef DIFFTEST_WB_FILTER_X0_EN
      check_eq("x0_valid", out_valid, 1'b0);
`else
      check_eq("x0_valid", out_valid, 1'b1);
      check_eq("x0_addr", out_address, 5'd0);
      check_eq("x0_data", out_data, 64'h5);
`endif
      idle(1, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
